// File: rtl/reg_bank_pkg.sv
// Shared definitions for the 32x32 register bank: default geometry and the
// write-port sweep state encoding.
package reg_bank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREG_DEF   = 1 << ADDR_W_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/reg_bank_write_port_if.sv
// Write request / clear-sweep bus between a requester (master) and the
// register bank write port (slave).
interface reg_bank_write_port_if import reg_bank_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              busy;
    logic              clr_done;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req,
        input  wr_ready, busy, clr_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req,
        output wr_ready, busy, clr_done
    );

endinterface

// File: rtl/reg_bank_write_port_decoder.sv
// 5-to-32 one-hot write-enable decoder; the write-side mirror of the bank's
// 32-to-1 read mux tree. All outputs are low when en_i is low.
module decoder5to32 import reg_bank_pkg::*; (
    input  logic [ADDR_W_DEF-1:0] sel_i,
    input  logic                  en_i,
    output logic [NREG_DEF-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_write_port.sv
// Write side of the register bank: valid/ready single-register writes, dirty
// tracking, a 32-cycle sequential clear sweep and flattened storage output.
module reg_bank_write_port import reg_bank_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    reg_bank_write_port_if.slave              wr,
    output logic [(1<<ADDR_W)-1:0]            dirty_o,
    output logic [(1<<ADDR_W)*DATA_W-1:0]     regs_flat_o
);

    localparam int NREG = 1 << ADDR_W;

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              wr_ready_q;
    logic              busy_q;
    logic              clr_done_q;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   dirty_q;
    logic [NREG-1:0]   dirty_d;
    logic [NREG-1:0]   wr_en;
    logic              accept;

    assign accept = wr.wr_valid & wr_ready_q;

    decoder5to32 u_dec (
        .sel_i    (wr.wr_addr),
        .en_i     (accept),
        .onehot_o (wr_en)
    );

    // Handshake outputs are registered and depend only on the sweep state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr.clr_req) begin
                        state_q    <= CLEAR;
                        idx_q      <= '0;
                        wr_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (idx_q == ADDR_W'(NREG - 1)) begin
                        state_q    <= IDLE;
                        idx_q      <= '0;
                        wr_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    idx_q      <= '0;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Writes can only be accepted in IDLE, so sweep and write never collide.
    always_comb begin
        regs_d  = regs_q;
        dirty_d = dirty_q;
        if (state_q == CLEAR) begin
            regs_d[idx_q]  = '0;
            dirty_d[idx_q] = 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i] && !(ZERO_REG && (i == 0))) begin
                    regs_d[i]  = wr.wr_data;
                    dirty_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            dirty_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            dirty_q <= dirty_d;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs_flat_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign dirty_o     = dirty_q;
    assign wr.wr_ready = wr_ready_q;
    assign wr.busy     = busy_q;
    assign wr.clr_done = clr_done_q;

endmodule
